// File: rtl/cpu_pkg.sv
// Shared CPU definitions: run-state encoding, defaults and the
// control-flow class priority used by the branch/PC stage.
package cpu_pkg;

  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  localparam int          OFF_W_DEF    = 27;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_e;

  typedef enum logic [2:0] {
    CLS_NONE = 3'd0,
    CLS_RET  = 3'd1,
    CLS_CALL = 3'd2,
    CLS_B    = 3'd3,
    CLS_BEQ  = 3'd4,
    CLS_BGT  = 3'd5,
    CLS_HLT  = 3'd6
  } cls_e;

  // Malformed decode (several classes high) resolves as
  // ret > call > b > beq > bgt > hlt.
  function automatic cls_e decode_cls(
    input logic is_ret,
    input logic is_call,
    input logic is_b,
    input logic is_beq,
    input logic is_bgt,
    input logic is_hlt
  );
    cls_e c;
    if (is_ret)       c = CLS_RET;
    else if (is_call) c = CLS_CALL;
    else if (is_b)    c = CLS_B;
    else if (is_beq)  c = CLS_BEQ;
    else if (is_bgt)  c = CLS_BGT;
    else if (is_hlt)  c = CLS_HLT;
    else              c = CLS_NONE;
    return c;
  endfunction

endpackage

// File: rtl/branch_target_calc.sv
// Combinational branch target and next-PC selection for the
// branch/PC stage.
module branch_target_calc
  import cpu_pkg::*;
#(
  parameter int PC_W  = 32,
  parameter int OFF_W = OFF_W_DEF
) (
  input  logic [PC_W-1:0]  i_pc,
  input  logic [OFF_W-1:0] i_br_off,
  input  logic [PC_W-1:0]  i_ra_val,
  input  cls_e             i_cls,
  input  logic             i_adv,
  input  logic             i_eq,
  input  logic             i_gt,
  output logic [PC_W-1:0]  o_pc_plus4,
  output logic [PC_W-1:0]  o_next_pc,
  output logic             o_taken
);

  logic [PC_W-1:0] w_sext;
  logic [PC_W-1:0] w_tgt;

  assign w_sext     = {{(PC_W-OFF_W){i_br_off[OFF_W-1]}}, i_br_off};
  assign w_tgt      = i_pc + (w_sext << 2);
  assign o_pc_plus4 = i_pc + PC_W'(4);

  // Pick the redirect decision and the PC for next cycle.
  always_comb begin
    o_taken   = 1'b0;
    o_next_pc = i_pc;
    if (i_adv) begin
      unique case (i_cls)
        CLS_RET: begin
          o_taken   = 1'b1;
          o_next_pc = i_ra_val;
        end
        CLS_CALL, CLS_B: begin
          o_taken   = 1'b1;
          o_next_pc = w_tgt;
        end
        CLS_BEQ: begin
          o_taken   = i_eq;
          o_next_pc = i_eq ? w_tgt : o_pc_plus4;
        end
        CLS_BGT: begin
          o_taken   = i_gt;
          o_next_pc = i_gt ? w_tgt : o_pc_plus4;
        end
        CLS_HLT: o_next_pc = i_pc;
        default: o_next_pc = o_pc_plus4;
      endcase
    end
  end

endmodule

// File: rtl/branch_pc_unit.sv
// Branch/PC stage: PC register, run/halt FSM, r15 link write,
// fetch flush pulse and retired/taken counters.
module branch_pc_unit
  import cpu_pkg::*;
#(
  parameter int              PC_W     = 32,
  parameter logic [PC_W-1:0] RESET_PC = PC_W'(RESET_PC_DEF),
  parameter int              OFF_W    = OFF_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stall,
  input  logic             instr_valid,
  input  logic             isB,
  input  logic             isBeq,
  input  logic             isBgt,
  input  logic             isCall,
  input  logic             isRet,
  input  logic             isHlt,
  input  logic [OFF_W-1:0] br_off,
  input  logic [PC_W-1:0]  ra_val,
  input  logic             eq_flag,
  input  logic             gt_flag,
  output logic [PC_W-1:0]  pc,
  output logic [PC_W-1:0]  pc_plus4,
  output logic             ra_wr_en,
  output logic [PC_W-1:0]  ra_wr_data,
  output logic             taken,
  output logic             flush,
  output logic             halted,
  output logic [PC_W-1:0]  retired_cnt,
  output logic [PC_W-1:0]  taken_cnt
);

  state_e          r_state;
  logic [PC_W-1:0] r_pc;
  logic [PC_W-1:0] r_ret_cnt;
  logic [PC_W-1:0] r_tkn_cnt;
  logic            r_flush;

  logic            w_run;
  logic            w_adv;
  cls_e            w_cls;
  logic [PC_W-1:0] w_pc4;
  logic [PC_W-1:0] w_next;
  logic            w_taken;

  assign w_run = (r_state == ST_RUN);
  assign w_adv = w_run & instr_valid & ~stall;
  assign w_cls = decode_cls(isRet, isCall, isB,
                            isBeq, isBgt, isHlt);

  branch_target_calc #(
    .PC_W  (PC_W),
    .OFF_W (OFF_W)
  ) u_tgt (
    .i_pc       (r_pc),
    .i_br_off   (br_off),
    .i_ra_val   (ra_val),
    .i_cls      (w_cls),
    .i_adv      (w_adv),
    .i_eq       (eq_flag),
    .i_gt       (gt_flag),
    .o_pc_plus4 (w_pc4),
    .o_next_pc  (w_next),
    .o_taken    (w_taken)
  );

  assign pc          = r_pc;
  assign pc_plus4    = w_run ? w_pc4 : '0;
  assign ra_wr_en    = w_adv & (w_cls == CLS_CALL);
  assign ra_wr_data  = pc_plus4;
  assign taken       = w_taken;
  assign flush       = r_flush;
  assign halted      = (r_state == ST_HALT);
  assign retired_cnt = r_ret_cnt;
  assign taken_cnt   = r_tkn_cnt;

  // Run/halt FSM with PC, flush and counter updates.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_pc      <= RESET_PC;
      r_flush   <= 1'b0;
      r_ret_cnt <= '0;
      r_tkn_cnt <= '0;
    end else begin
      r_flush <= w_taken;
      unique case (r_state)
        ST_IDLE: begin
          if (start && !stall) r_state <= ST_RUN;
        end
        ST_RUN: begin
          r_pc <= w_next;
          if (w_adv)
            r_ret_cnt <= r_ret_cnt + 1'b1;
          if (w_taken)
            r_tkn_cnt <= r_tkn_cnt + 1'b1;
          if (w_adv && w_cls == CLS_HLT)
            r_state <= ST_HALT;
        end
        ST_HALT: r_state <= ST_HALT;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_branch_pc_unit.sv
// Self-checking bench for branch_pc_unit: cycle model plus
// directed control-flow scenarios with literal expectations.
module tb_branch_pc_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        stall = 1'b0;
  logic        instr_valid = 1'b0;
  logic        isB = 1'b0, isBeq = 1'b0, isBgt = 1'b0;
  logic        isCall = 1'b0, isRet = 1'b0, isHlt = 1'b0;
  logic [26:0] br_off = '0;
  logic [31:0] ra_val = '0;
  logic        eq_flag = 1'b0, gt_flag = 1'b0;

  logic [31:0] pc, pc_plus4, ra_wr_data, retired_cnt, taken_cnt;
  logic        ra_wr_en, taken, flush, halted;

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  branch_pc_unit dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .stall       (stall),
    .instr_valid (instr_valid),
    .isB         (isB),
    .isBeq       (isBeq),
    .isBgt       (isBgt),
    .isCall      (isCall),
    .isRet       (isRet),
    .isHlt       (isHlt),
    .br_off      (br_off),
    .ra_val      (ra_val),
    .eq_flag     (eq_flag),
    .gt_flag     (gt_flag),
    .pc          (pc),
    .pc_plus4    (pc_plus4),
    .ra_wr_en    (ra_wr_en),
    .ra_wr_data  (ra_wr_data),
    .taken       (taken),
    .flush       (flush),
    .halted      (halted),
    .retired_cnt (retired_cnt),
    .taken_cnt   (taken_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Model state: 0 idle, 1 running, 2 halted.
  int          m_st;
  logic [31:0] m_pc, m_ret, m_tk;
  logic        m_flush;

  logic        e_adv, e_taken, e_call, e_halt;
  logic [31:0] e_next, e_pc4, e_tgt, e_off;

  always_comb begin
    e_adv   = (m_st == 1) && instr_valid && !stall;
    e_off   = {{5{br_off[26]}}, br_off};
    e_pc4   = m_pc + 32'd4;
    e_tgt   = m_pc + e_off * 32'd4;
    e_next  = m_pc;
    e_taken = 1'b0;
    e_call  = 1'b0;
    e_halt  = 1'b0;
    if (e_adv) begin
      if (isRet) begin
        e_taken = 1'b1; e_next = ra_val;
      end else if (isCall) begin
        e_taken = 1'b1; e_call = 1'b1; e_next = e_tgt;
      end else if (isB) begin
        e_taken = 1'b1; e_next = e_tgt;
      end else if (isBeq) begin
        e_taken = eq_flag; e_next = eq_flag ? e_tgt : e_pc4;
      end else if (isBgt) begin
        e_taken = gt_flag; e_next = gt_flag ? e_tgt : e_pc4;
      end else if (isHlt) begin
        e_halt = 1'b1;
      end else begin
        e_next = e_pc4;
      end
    end
  end

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_st <= 0; m_pc <= '0; m_ret <= '0;
      m_tk <= '0; m_flush <= 1'b0;
    end else begin
      m_flush <= e_taken;
      if (m_st == 0 && start && !stall) m_st <= 1;
      if (m_st == 1) begin
        m_pc <= e_next;
        if (e_adv) m_ret <= m_ret + 32'd1;
        if (e_taken) m_tk <= m_tk + 32'd1;
        if (e_halt) m_st <= 2;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_pc", pc, m_pc);
      chk("m_pc4", pc_plus4, (m_st == 1) ? e_pc4 : 32'd0);
      chk("m_ra_en", {31'd0, ra_wr_en}, {31'd0, e_call});
      chk("m_ra_dat", ra_wr_data, (m_st == 1) ? e_pc4 : 32'd0);
      chk("m_taken", {31'd0, taken}, {31'd0, e_taken});
      chk("m_flush", {31'd0, flush}, {31'd0, m_flush});
      chk("m_halted", {31'd0, halted}, {31'd0, m_st == 2});
      chk("m_retired", retired_cnt, m_ret);
      chk("m_tkcnt", taken_cnt, m_tk);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_cls();
    isB = 0; isBeq = 0; isBgt = 0;
    isCall = 0; isRet = 0; isHlt = 0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk_en = 1'b1;
    chk("rst_pc", pc, 32'h0);
    chk("rst_halted", {31'd0, halted}, 32'd0);
    chk("rst_ret", retired_cnt, 32'd0);
    chk("rst_flush", {31'd0, flush}, 32'd0);
    chk("rst_pc4", pc_plus4, 32'd0);
    reset = 0;
    start = 1; cyc();
    start = 0; instr_valid = 1;
    repeat (3) cyc();
    chk("seq_pc", pc, 32'd12);
    chk("seq_ret", retired_cnt, 32'd3);
    chk("seq_flush", {31'd0, flush}, 32'd0);
    cyc();
    chk("pc_10", pc, 32'h10);

    isBeq = 1; eq_flag = 1; br_off = 27'd5; #1;
    chk("beq_taken", {31'd0, taken}, 32'd1);
    cyc();
    chk("beq_pc", pc, 32'h24);
    chk("beq_flush", {31'd0, flush}, 32'd1);
    chk("beq_tk", taken_cnt, 32'd1);
    clr_cls(); instr_valid = 0; cyc();
    chk("beq_flush0", {31'd0, flush}, 32'd0);

    instr_valid = 1; isB = 1; br_off = 27'h7FF_FFFB; cyc();
    chk("b_back", pc, 32'h10);
    clr_cls(); isBeq = 1; eq_flag = 0; br_off = 27'd5; cyc();
    chk("beq_nt_pc", pc, 32'h14);
    chk("beq_nt_tk", taken_cnt, 32'd2);

    clr_cls(); isB = 1; br_off = 27'd11; cyc();
    chk("b_40", pc, 32'h40);
    clr_cls(); isCall = 1; br_off = 27'h7FF_FFFC; #1;
    chk("call_en", {31'd0, ra_wr_en}, 32'd1);
    chk("call_dat", ra_wr_data, 32'h44);
    cyc();
    chk("call_pc", pc, 32'h30);
    clr_cls(); isRet = 1; ra_val = 32'h44; cyc();
    chk("ret_pc", pc, 32'h44);
    chk("ret_tk", taken_cnt, 32'd5);

    clr_cls(); isBgt = 1; gt_flag = 1; br_off = 27'd2; stall = 1;
    repeat (3) cyc();
    chk("stl_pc", pc, 32'h44);
    chk("stl_tk", taken_cnt, 32'd5);
    chk("stl_flush", {31'd0, flush}, 32'd0);
    chk("stl_taken", {31'd0, taken}, 32'd0);
    stall = 0; #1;
    chk("bgt_taken", {31'd0, taken}, 32'd1);
    cyc();
    chk("bgt_pc", pc, 32'h4C);
    chk("bgt_flush", {31'd0, flush}, 32'd1);
    chk("bgt_tk", taken_cnt, 32'd6);

    clr_cls(); isRet = 1; isB = 1; ra_val = 32'h100; cyc();
    chk("conf_pc", pc, 32'h100);
    chk("conf_x", {31'd0, $isunknown({pc, pc_plus4, ra_wr_en,
        ra_wr_data, taken, flush, halted, retired_cnt,
        taken_cnt})}, 32'd0);

    clr_cls(); isB = 1; br_off = 27'h7FF_FFE0; cyc();
    chk("b_80", pc, 32'h80);
    clr_cls(); isHlt = 1; cyc();
    chk("hlt_halted", {31'd0, halted}, 32'd1);
    chk("hlt_pc", pc, 32'h80);
    clr_cls(); isB = 1; start = 1;
    repeat (10) cyc();
    chk("hlt_hold", pc, 32'h80);
    chk("hlt_stay", {31'd0, halted}, 32'd1);

    #2 reset = 1; #1;
    chk("arst_pc", pc, 32'h0);
    chk("arst_halt", {31'd0, halted}, 32'd0);
    chk("arst_ret", retired_cnt, 32'd0);
    cyc();
    reset = 0; clr_cls(); cyc();
    start = 0; isRet = 1; ra_val = 32'hFFFF_FFFC; cyc();
    chk("wrap_pc", pc, 32'hFFFF_FFFC);
    clr_cls(); #1;
    chk("wrap_pc4", pc_plus4, 32'h0);
    cyc();
    chk("wrap_0", pc, 32'h0);
    instr_valid = 0; repeat (2) cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/branch_pc_unit.md
Name: branch_pc_unit

Overview:
- Program-counter and control-flow stage that sits directly downstream of the ALU add/sub/compare stage.
- Consumes the registered Eq/Gt flags that a CMP writes, and resolves b, beq, bgt, call, ret and hlt for the instruction at the current PC.
- Owns the PC register, the run/halt state machine, the return-address write to r15, a one-cycle fetch-flush pulse on redirect, and retired/taken counters.

Parameters:
- PC_W, 32, width of PC, return-address value and counters.
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- OFF_W, 27, width of the signed word offset field of branch instructions.

Ports:
- clk  in  1  clock.
- reset  in  1  reset.
- start  in  1  leave IDLE and begin fetching.
- stall  in  1  hold PC, state and counters this cycle.
- instr_valid  in  1  decode is presenting the instruction at pc.
- isB / isBeq / isBgt / isCall / isRet / isHlt  in  1 each  decoded control-flow class (one-hot or all zero).
- br_off  in  OFF_W  signed word offset.
- ra_val  in  PC_W  current r15 contents from the register file.
- eq_flag, gt_flag  in  1 each  registered compare flags.
- pc  out  PC_W  current fetch PC.
- pc_plus4  out  PC_W  pc+4, combinational.
- ra_wr_en  out  1  write r15 this cycle.
- ra_wr_data  out  PC_W  value written to r15 (= pc_plus4).
- taken  out  1  combinational redirect decision this cycle.
- flush  out  1  registered, drop prefetched word.
- halted  out  1  in HALT state.
- retired_cnt  out  PC_W  instructions retired.
- taken_cnt  out  PC_W  redirects taken.

Behaviour:
- Reset is asynchronous and active-high; the clock is clk. Reset may assert at any time, including mid-operation or during a stall.
- Reset values: pc=RESET_PC, state=IDLE, flush=0, halted=0, both counters=0. Combinational outputs are 0 because they are gated by RUN.
- State IDLE: pc holds. start=1 -> RUN next cycle. All instruction inputs are ignored.
- State RUN, "advance" = instr_valid & ~stall:
  - taken = advance & (isRet | isCall | isB | (isBeq & eq_flag) | (isBgt & gt_flag)).
  - Next PC priority: isRet -> ra_val. Otherwise isCall/isB/taken beq/bgt -> pc + (sign_ext(br_off) << 2), computed modulo 2^PC_W. Otherwise advance -> pc+4. Otherwise hold.
  - If more than one is* is high, priority is ret > call > b > beq > bgt. This is a decode error and must not cause X.
  - ra_wr_en = advance & isCall; ra_wr_data = pc_plus4. A call and a ret are never both honoured.
  - flush <= taken, giving exactly one cycle high after each redirect. Back-to-back taken keeps flush high.
  - retired_cnt increments by 1 on each advance, wrapping at 2^PC_W. taken_cnt increments on taken.
  - advance & isHlt (no other is* set) -> HALT. pc holds at the hlt address. The hlt counts as retired.
- stall=1 in any state: no PC/state/counter change, taken=0, ra_wr_en=0, flush <= 0.
- State HALT: halted=1, everything frozen, start ignored. Only reset exits.
- Flags are sampled combinationally in the same cycle. A CMP in cycle N makes its flags visible to a beq in cycle N+1 with no interlock.
- PC wrap-around: pc+4 from 32'hFFFF_FFFC gives 0, with no error.

Decomposition:
- Shared package (cpu_pkg): state encoding (IDLE/RUN/HALT), the RESET_PC default, OFF_W, and the instruction-class priority order.
- One sub-module, branch_target_calc: combinational sign-extend, shift, add and next-PC mux. The FSM, PC register, flush and counters stay in the top.

Test Plan:
- Reset, then start, then 3 non-branch instructions -> pc goes 0,4,8,12; retired_cnt=3; flush stays 0.
- CMP leaves eq_flag=1, then beq with br_off=5 at pc=0x10 -> next pc 0x24; flush=1 for one cycle; taken_cnt=1. Same case with eq_flag=0 -> pc 0x14.
- call at pc=0x40 with br_off=-4 -> ra_wr_en=1, ra_wr_data=0x44, next pc 0x30. Then ret with ra_val=0x44 -> pc 0x44.
- stall held 3 cycles during a taken bgt -> pc, counters and flush unchanged; redirect happens on the first unstalled cycle.
- hlt at pc=0x80 -> halted=1, pc stays 0x80 for 10 cycles despite start=1; async reset mid-cycle -> pc=0, IDLE, halted=0.
- Conflicting isRet=isB=1 with ra_val=0x100 -> pc=0x100, no X on any output.
